ifm_pause_ctrl: RTL



---
 rtl/ifm_pkg.sv | 23 ++
 rtl/ifm_pause_ctrl_if.sv | 18 +
 rtl/ifm_dn_timer.sv | 37 +++
 rtl/ifm_pause_ctrl.sv | 130 +++++++++++++
 4 files changed

// File: rtl/ifm_pkg.sv
// Shared types and defaults for the RX flow-control (pause frame) logic.
// Watermark defaults are also used to size the RX input FIFO.
package ifm_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_XOFF = 2'd1,
        S_HOLD = 2'd2
    } pause_state_e;

    localparam int          C_CNT_W_DEF   = 12;
    localparam int          C_HI_WM_DEF   = 3072;
    localparam int          C_LO_WM_DEF   = 1024;
    localparam logic [15:0] C_QUANTA_DEF  = 16'h0080;
    localparam int          C_REFRESH_DEF = 768;
    localparam int          C_HOLD_DEF    = 64;

    typedef struct packed {
        logic        req;
        logic [15:0] val;
    } pause_cmd_t;

endpackage

// File: rtl/ifm_pause_ctrl_if.sv
// Pause request channel from the flow-control scheduler to the MAC.
interface ifm_pause_ctrl_if;
    import ifm_pkg::*;

    logic        pause_req;
    logic [15:0] pause_val;

    modport master (
        output pause_req,
        output pause_val
    );

    modport slave (
        input pause_req,
        input pause_val
    );

endinterface

// File: rtl/ifm_dn_timer.sv
// Loadable 16-bit down-counter; saturates at zero, load wins over decrement.
module ifm_dn_timer
    import ifm_pkg::*;
(
    input  logic        rx_clk,
    input  logic        sys_rst,
    input  logic        load,
    input  logic [15:0] load_val,
    input  logic        dec,
    output logic [15:0] cnt,
    output logic        zero
);

    logic [15:0] cnt_q;
    logic [15:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (dec && (cnt_q != 16'd0)) begin
            cnt_d = cnt_q - 16'd1;
        end
    end

    always_ff @(posedge rx_clk or posedge sys_rst) begin
        if (sys_rst) begin
            cnt_q <= 16'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt  = cnt_q;
    assign zero = (cnt_q == 16'd0);

endmodule

// File: rtl/ifm_pause_ctrl.sv
// RX flow-control scheduler: issues XOFF on high watermark, refreshes it
// while congested, and releases with XON (quanta 0) below the low watermark.
module ifm_pause_ctrl
    import ifm_pkg::*;
#(
    parameter int          C_CNT_W   = C_CNT_W_DEF,
    parameter int          C_HI_WM   = C_HI_WM_DEF,
    parameter int          C_LO_WM   = C_LO_WM_DEF,
    parameter logic [15:0] C_QUANTA  = C_QUANTA_DEF,
    parameter int          C_REFRESH = C_REFRESH_DEF,
    parameter int          C_HOLD    = C_HOLD_DEF,
    parameter int          C_XON_EN  = 1
) (
    input  logic               rx_clk,
    input  logic               sys_rst,
    input  logic               cfg_pause_en,
    input  logic [C_CNT_W-1:0] wr_data_count,
    ifm_pause_ctrl_if.master   pif,
    output logic               xoff_active,
    output logic [15:0]        pause_cnt,
    output logic [1:0]         pause_fsm_dbg
);

    localparam logic [C_CNT_W-1:0] HI_LV  = C_CNT_W'(C_HI_WM);
    localparam logic [C_CNT_W-1:0] LO_LV  = C_CNT_W'(C_LO_WM);
    localparam logic [15:0]        REF_LD = 16'(C_REFRESH - 1);
    localparam logic [15:0]        HLD_LD = 16'(C_HOLD - 1);

    pause_state_e state_q, state_d;
    pause_cmd_t   cmd_d;
    logic         pause_req_q;
    logic [15:0]  pause_val_q;
    logic         xoff_active_q, xoff_active_d;
    logic [15:0]  pause_cnt_q, pause_cnt_d;

    logic         tmr_load;
    logic [15:0]  tmr_load_val;
    logic         tmr_dec;
    logic [15:0]  tmr_cnt;
    logic         tmr_zero;

    logic         hi_hit;
    logic         lo_hit;

    assign hi_hit = (wr_data_count >= HI_LV);
    assign lo_hit = (wr_data_count < LO_LV);

    ifm_dn_timer u_timer (
        .rx_clk   (rx_clk),
        .sys_rst  (sys_rst),
        .load     (tmr_load),
        .load_val (tmr_load_val),
        .dec      (tmr_dec),
        .cnt      (tmr_cnt),
        .zero     (tmr_zero)
    );

    always_comb begin
        state_d      = state_q;
        cmd_d.req    = 1'b0;
        cmd_d.val    = pause_val_q;
        tmr_load     = 1'b0;
        tmr_load_val = 16'd0;
        tmr_dec      = 1'b0;
        case (state_q)
            S_XOFF: begin
                tmr_dec = 1'b1;
                // release outranks a refresh falling due in the same cycle
                if (!cfg_pause_en || lo_hit) begin
                    state_d      = S_HOLD;
                    tmr_load     = 1'b1;
                    tmr_load_val = HLD_LD;
                    if (C_XON_EN != 0) begin
                        cmd_d.req = 1'b1;
                        cmd_d.val = 16'h0000;
                    end
                end else if (tmr_zero) begin
                    cmd_d.req    = 1'b1;
                    cmd_d.val    = C_QUANTA;
                    tmr_load     = 1'b1;
                    tmr_load_val = REF_LD;
                end
            end
            S_HOLD: begin
                tmr_dec = 1'b1;
                if (tmr_zero) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
                if (cfg_pause_en && hi_hit) begin
                    state_d      = S_XOFF;
                    cmd_d.req    = 1'b1;
                    cmd_d.val    = C_QUANTA;
                    tmr_load     = 1'b1;
                    tmr_load_val = REF_LD;
                end
            end
        endcase
        xoff_active_d = (state_d == S_XOFF);
        pause_cnt_d   = pause_cnt_q + {15'd0, cmd_d.req};
    end

    always_ff @(posedge rx_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state_q       <= S_IDLE;
            pause_req_q   <= 1'b0;
            pause_val_q   <= 16'h0000;
            xoff_active_q <= 1'b0;
            pause_cnt_q   <= 16'd0;
        end else begin
            state_q       <= state_d;
            pause_req_q   <= cmd_d.req;
            pause_val_q   <= cmd_d.val;
            xoff_active_q <= xoff_active_d;
            pause_cnt_q   <= pause_cnt_d;
        end
    end

    assign pif.pause_req  = pause_req_q;
    assign pif.pause_val  = pause_val_q;
    assign xoff_active    = xoff_active_q;
    assign pause_cnt      = pause_cnt_q;
    assign pause_fsm_dbg  = state_q;

    logic unused_ok;
    assign unused_ok = ^tmr_cnt;

endmodule
